alarm_scheduler: RTL and testbench
==================================

# alarm_scheduler

Arbitrates the kit's alarm sources (dose reminder, missed dose, fault) and sequences the shared buzzer. Drives the 4-bit alarm state code consumed by `buzzerDriver.state_in` with an on/off cadence, repetition limit, user acknowledge and priority preemption. Sits between the kit's event logic and `buzzerDriver`, clocked by `clk_base` and paced by a slow tick enable.

## Interface
- `ON_TICKS`, default 2: ticks the alarm code is driven per beep.
- `OFF_TICKS`, default 2: silent ticks between beeps.
- `MAX_CYCLES`, default 8: beep cycles before auto-timeout, range 1..255.

- `clk_base`, in, 1: the single clock; all state changes on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `tick`, in, 1: one-`clk_base`-cycle cadence enable.
- `req`, in, 3: level requests. Bit 0 is reminder, bit 1 is missed dose, bit 2 is fault.
- `ack`, in, 1: one-cycle user acknowledge pulse.
- `state_out`, out, 4: connects to `buzzerDriver.state_in`. Values: 0110 reminder, 0111 missed, 1000 fault, 0000 silent.
- `grant`, out, 3: one-hot source being served; 000 when idle.
- `active`, out, 1: high in ON and OFF.
- `timeout`, out, 1: one-cycle pulse when `MAX_CYCLES` completes unacknowledged.

## Operation
- FSM states:
  - IDLE: `state_out`=0000, `grant`=000.
  - ON: `state_out`=code of the granted source.
  - OFF: `state_out`=0000, `grant` held.
- `mask[2:0]`:
  - Set for the granted source on `ack` or on timeout.
  - Each bit clears on any cycle its `req` bit is low.
  - Eligible requests are `req & ~mask`.
- Arbitration is fixed priority: fault > missed > reminder.
- IDLE → ON when any eligible request exists. On entry: grant the winner, clear the tick and cycle counters.
- ON → OFF on the tick that brings the tick counter to `ON_TICKS`; the tick counter clears.
- OFF → ON on the tick that brings the tick counter to `OFF_TICKS`; the cycle counter increments.
- Timeout: if the incremented cycle count equals `MAX_CYCLES`, pulse `timeout`, set the mask bit, and go to IDLE. Do not return to ON.
- Preemption: in ON or OFF, a higher-priority eligible request takes effect next edge. The FSM enters ON with the new grant and both counters clear.
- Served source's `req` drops in ON or OFF: go to IDLE next edge. Re-arbitration follows normal IDLE rules.
- `ack` in ON or OFF: set the mask bit of the granted source. Then re-arbitrate the same edge: a remaining eligible source enters ON with cleared counters, otherwise go to IDLE. `ack` in IDLE is ignored.
- Simultaneous events, in priority order:
  - `ack` beats `tick`.
  - `ack` with preemption: mask the current source, then serve the higher one.
  - Timeout with preemption: timeout pulses and the mask is set, then the preemptor is served.
- Counter widths: tick counter is 8 bits; cycle counter is 8 bits. Neither wraps, because both are compared before increment.

## Timing
- All outputs are registered.
- Inputs sampled at edge k produce new outputs immediately after edge k. Request-to-code latency is 1 edge.
- ON lasts exactly `ON_TICKS` ticks and OFF lasts exactly `OFF_TICKS` ticks, counted from the entering edge. A tick on the entering edge is not counted.
- `timeout` is high for exactly one `clk_base` cycle.
- Reset (asynchronous, any state, including mid-beep) forces IDLE. Reset values: `state_out`=0000, `grant`=000, `active`=0, `timeout`=0, mask=000, counters=0.
- First arbitration occurs on the first edge after `rst_n` deasserts.

## Structure
- `medikit_pkg` holds:
  - Code constants `CODE_IDLE` (0000), `CODE_REMIND` (0110), `CODE_MISSED` (0111), `CODE_FAULT` (1000).
  - Source index constants.
  - The FSM state typedef (IDLE/ON/OFF).
- Sub-module `prio_arbiter` (combinational, 3-bit fixed priority):
  - Inputs: `req`, `mask`.
  - Outputs: one-hot winner and valid.
  - Instantiated once.

## Test plan
- Reminder only, ON=2/OFF=2/MAX=3, ticks every 4 clocks → `state_out` 0110/0000 alternates 3 times. Then `timeout` pulses once, state goes to IDLE, and stays 0000 while `req[0]` remains high.
- Reminder in ON, assert `req[2]` → next edge `state_out`=1000, `grant`=100, counters restart with a full `ON_TICKS`.
- Fault and reminder held, `ack` during fault ON → fault masked; reminder enters ON with 0110 on the same edge.
- Drop and reassert `req[2]` after ack → mask clears; fault alarm restarts at 1000.
- `ack` and `tick` on the same cycle in ON → ack wins; no OFF transition is taken from that tick.
- `rst_n` low mid-OFF with requests pending → outputs go to 0000/000/0/0 asynchronously. After release, fault wins: 1000 appears one edge later.

Source files
------------

// File: rtl/medikit_pkg.sv
// Shared constants and types for the medikit alarm path: buzzer state codes,
// alarm source bit positions and the alarm scheduler FSM state type.
package medikit_pkg;

  localparam logic [3:0] CODE_IDLE   = 4'b0000;
  localparam logic [3:0] CODE_REMIND = 4'b0110;
  localparam logic [3:0] CODE_MISSED = 4'b0111;
  localparam logic [3:0] CODE_FAULT  = 4'b1000;

  localparam int SRC_REMIND = 0;
  localparam int SRC_MISSED = 1;
  localparam int SRC_FAULT  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  // Map a one-hot grant to the buzzer code of that source.
  function automatic logic [3:0] code_of(input logic [2:0] sel);
    logic [3:0] code;
    code = CODE_IDLE;
    if (sel[SRC_FAULT])       code = CODE_FAULT;
    else if (sel[SRC_MISSED]) code = CODE_MISSED;
    else if (sel[SRC_REMIND]) code = CODE_REMIND;
    return code;
  endfunction

endpackage

// File: rtl/prio_arbiter.sv
// Combinational fixed-priority picker for the three alarm sources.
// Fault beats missed dose, missed dose beats reminder; masked sources never win.
module prio_arbiter
  import medikit_pkg::*;
(
  input  logic [2:0] req,
  input  logic [2:0] mask,
  output logic [2:0] win,
  output logic       valid
);

  logic [2:0] elig;

  // Pick the highest-priority unmasked request as a one-hot winner.
  always_comb begin
    elig  = req & ~mask;
    win   = 3'b000;
    valid = |elig;
    if (elig[SRC_FAULT])       win[SRC_FAULT]  = 1'b1;
    else if (elig[SRC_MISSED]) win[SRC_MISSED] = 1'b1;
    else if (elig[SRC_REMIND]) win[SRC_REMIND] = 1'b1;
  end

endmodule

// File: rtl/alarm_scheduler.sv
// Alarm scheduler: arbitrates reminder / missed-dose / fault requests and
// sequences the shared buzzer code with an on/off cadence, a beep-cycle
// limit, user acknowledge and priority preemption. All outputs registered.
module alarm_scheduler
  import medikit_pkg::*;
#(
  parameter int ON_TICKS   = 2,
  parameter int OFF_TICKS  = 2,
  parameter int MAX_CYCLES = 8
) (
  input  logic       clk_base,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [2:0] req,
  input  logic       ack,
  output logic [3:0] state_out,
  output logic [2:0] grant,
  output logic       active,
  output logic       timeout
);

  state_t     state;
  logic [2:0] mask;
  logic [7:0] tick_cnt;
  logic [7:0] cycle_cnt;

  logic [2:0] arb_mask;
  logic [2:0] win;
  logic       win_valid;

  logic       serving;
  logic       preempt;
  logic       dropped;
  logic       on_done;
  logic       off_done;
  logic       cyc_done;
  logic       to_evt;
  logic [2:0] mask_set;

  // An ack hides the current source from the arbiter so the same edge can
  // hand the buzzer straight to whatever is still eligible.
  always_comb begin
    arb_mask = mask;
    if (serving && ack) arb_mask = mask | grant;
  end

  prio_arbiter u_arb (
    .req   (req),
    .mask  (arb_mask),
    .win   (win),
    .valid (win_valid)
  );

  // Event decode for the current cycle; ack outranks any tick-driven event.
  always_comb begin
    serving  = (state != IDLE);
    preempt  = serving && win_valid && (ack || (win > grant));
    dropped  = serving && ((req & grant) == 3'b000);
    on_done  = (state == ON)  && tick && ((tick_cnt + 8'd1) == 8'(ON_TICKS));
    off_done = (state == OFF) && tick && ((tick_cnt + 8'd1) == 8'(OFF_TICKS));
    cyc_done = off_done && ((cycle_cnt + 8'd1) == 8'(MAX_CYCLES));
    to_evt   = cyc_done && !ack && (preempt || !dropped);
    mask_set = 3'b000;
    if ((serving && ack) || to_evt) mask_set = grant;
  end

  // Scheduler FSM with registered outputs and the per-source mask.
  always_ff @(posedge clk_base or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mask      <= 3'b000;
      tick_cnt  <= 8'd0;
      cycle_cnt <= 8'd0;
      state_out <= CODE_IDLE;
      grant     <= 3'b000;
      active    <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      mask    <= (mask | mask_set) & req;
      case (state)
        IDLE: begin
          if (win_valid) begin
            state     <= ON;
            grant     <= win;
            state_out <= code_of(win);
            active    <= 1'b1;
            tick_cnt  <= 8'd0;
            cycle_cnt <= 8'd0;
          end
        end
        ON, OFF: begin
          if (preempt) begin
            state     <= ON;
            grant     <= win;
            state_out <= code_of(win);
            active    <= 1'b1;
            tick_cnt  <= 8'd0;
            cycle_cnt <= 8'd0;
            timeout   <= to_evt;
          end else if (ack || dropped || to_evt) begin
            state     <= IDLE;
            grant     <= 3'b000;
            state_out <= CODE_IDLE;
            active    <= 1'b0;
            tick_cnt  <= 8'd0;
            cycle_cnt <= 8'd0;
            timeout   <= to_evt;
          end else if (on_done) begin
            state     <= OFF;
            state_out <= CODE_IDLE;
            tick_cnt  <= 8'd0;
          end else if (off_done) begin
            state     <= ON;
            state_out <= code_of(grant);
            tick_cnt  <= 8'd0;
            cycle_cnt <= cycle_cnt + 8'd1;
          end else if (tick) begin
            tick_cnt  <= tick_cnt + 8'd1;
          end
        end
        default: begin
          state     <= IDLE;
          grant     <= 3'b000;
          state_out <= CODE_IDLE;
          active    <= 1'b0;
          tick_cnt  <= 8'd0;
          cycle_cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed bench for alarm_scheduler with ON=2, OFF=2, MAX=3.
module tb_alarm_scheduler;

  logic       clk_base;
  logic       rst_n;
  logic       tick;
  logic [2:0] req;
  logic       ack;
  logic [3:0] state_out;
  logic [2:0] grant;
  logic       active;
  logic       timeout;

  int checks;
  int errors;

  typedef struct {
    logic       tick;
    logic [2:0] req;
    logic       ack;
    logic [3:0] code;
    logic [2:0] gnt;
    logic       act;
    logic       tmo;
    string      name;
  } vec_t;

  vec_t vecs[$];

  alarm_scheduler #(
    .ON_TICKS   (2),
    .OFF_TICKS  (2),
    .MAX_CYCLES (3)
  ) dut (
    .clk_base  (clk_base),
    .rst_n     (rst_n),
    .tick      (tick),
    .req       (req),
    .ack       (ack),
    .state_out (state_out),
    .grant     (grant),
    .active    (active),
    .timeout   (timeout)
  );

  initial clk_base = 1'b0;
  always #5 clk_base = ~clk_base;

  task automatic addVec(input logic t, input logic [2:0] r, input logic a,
                        input logic [3:0] c, input logic [2:0] g,
                        input logic ac, input logic tm, input string n);
    vec_t v;
    v.tick = t; v.req = r; v.ack = a;
    v.code = c; v.gnt = g; v.act = ac; v.tmo = tm; v.name = n;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string n, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", n, got, exp);
    end
  endtask

  task automatic checkAll(input string n, input logic [3:0] c, input logic [2:0] g,
                          input logic ac, input logic tm);
    checkOutput({n, " state_out"}, state_out, c);
    checkOutput({n, " grant"}, {1'b0, grant}, {1'b0, g});
    checkOutput({n, " active"}, {3'b000, active}, {3'b000, ac});
    checkOutput({n, " timeout"}, {3'b000, timeout}, {3'b000, tm});
  endtask

  task automatic applyStimulus(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(negedge clk_base);
      tick = vecs[i].tick;
      req  = vecs[i].req;
      ack  = vecs[i].ack;
      @(posedge clk_base);
      #1;
      checkAll(vecs[i].name, vecs[i].code, vecs[i].gnt, vecs[i].act, vecs[i].tmo);
    end
  endtask

  initial begin
    int phase1_last;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    tick  = 1'b0;
    req   = 3'b000;
    ack   = 1'b0;

    // Phase 1: reminder cadence and timeout, preemption, ack handling.
    addVec(0, 3'b000, 0, 4'b0000, 3'b000, 0, 0, "v01 idle");
    addVec(1, 3'b001, 0, 4'b0110, 3'b001, 1, 0, "v02 rem on");
    addVec(0, 3'b001, 0, 4'b0110, 3'b001, 1, 0, "v03 on");
    addVec(1, 3'b001, 0, 4'b0110, 3'b001, 1, 0, "v04 on t1");
    addVec(1, 3'b001, 0, 4'b0000, 3'b001, 1, 0, "v05 off");
    addVec(1, 3'b001, 0, 4'b0000, 3'b001, 1, 0, "v06 off t1");
    addVec(1, 3'b001, 0, 4'b0110, 3'b001, 1, 0, "v07 on c1");
    addVec(1, 3'b001, 0, 4'b0110, 3'b001, 1, 0, "v08 on t1");
    addVec(1, 3'b001, 0, 4'b0000, 3'b001, 1, 0, "v09 off");
    addVec(1, 3'b001, 0, 4'b0000, 3'b001, 1, 0, "v10 off t1");
    addVec(1, 3'b001, 0, 4'b0110, 3'b001, 1, 0, "v11 on c2");
    addVec(1, 3'b001, 0, 4'b0110, 3'b001, 1, 0, "v12 on t1");
    addVec(1, 3'b001, 0, 4'b0000, 3'b001, 1, 0, "v13 off");
    addVec(1, 3'b001, 0, 4'b0000, 3'b001, 1, 0, "v14 off t1");
    addVec(1, 3'b001, 0, 4'b0000, 3'b000, 0, 1, "v15 timeout");
    addVec(0, 3'b001, 0, 4'b0000, 3'b000, 0, 0, "v16 masked");
    addVec(1, 3'b001, 0, 4'b0000, 3'b000, 0, 0, "v17 masked");
    addVec(0, 3'b000, 0, 4'b0000, 3'b000, 0, 0, "v18 drop");
    addVec(0, 3'b001, 0, 4'b0110, 3'b001, 1, 0, "v19 rem again");
    addVec(1, 3'b001, 0, 4'b0110, 3'b001, 1, 0, "v20 on t1");
    addVec(0, 3'b101, 0, 4'b1000, 3'b100, 1, 0, "v21 preempt");
    addVec(1, 3'b101, 0, 4'b1000, 3'b100, 1, 0, "v22 fault t1");
    addVec(0, 3'b101, 0, 4'b1000, 3'b100, 1, 0, "v23 fault");
    addVec(1, 3'b101, 0, 4'b0000, 3'b100, 1, 0, "v24 fault off");
    addVec(1, 3'b101, 0, 4'b0000, 3'b100, 1, 0, "v25 off t1");
    addVec(1, 3'b101, 0, 4'b1000, 3'b100, 1, 0, "v26 fault on");
    addVec(0, 3'b101, 1, 4'b0110, 3'b001, 1, 0, "v27 ack to rem");
    addVec(1, 3'b001, 0, 4'b0110, 3'b001, 1, 0, "v28 fault low");
    addVec(0, 3'b101, 0, 4'b1000, 3'b100, 1, 0, "v29 fault back");
    addVec(1, 3'b101, 0, 4'b1000, 3'b100, 1, 0, "v30 fault t1");
    addVec(1, 3'b101, 1, 4'b0110, 3'b001, 1, 0, "v31 ack beats tick");
    addVec(1, 3'b101, 0, 4'b0110, 3'b001, 1, 0, "v32 on t1");
    addVec(1, 3'b101, 0, 4'b0000, 3'b001, 1, 0, "v33 off");
    addVec(1, 3'b101, 0, 4'b0000, 3'b001, 1, 0, "v34 off t1");
    phase1_last = vecs.size() - 1;
    // Phase 2: after reset with fault served, drop it and walk the others.
    addVec(0, 3'b011, 0, 4'b0000, 3'b000, 0, 0, "p1 fault dropped");
    addVec(0, 3'b011, 0, 4'b0111, 3'b010, 1, 0, "p2 missed on");
    addVec(0, 3'b011, 1, 4'b0110, 3'b001, 1, 0, "p3 ack to rem");
    addVec(0, 3'b000, 0, 4'b0000, 3'b000, 0, 0, "p4 all dropped");

    repeat (2) @(posedge clk_base);
    #1;
    checkAll("reset", 4'b0000, 3'b000, 0, 0);
    @(negedge clk_base);
    rst_n = 1'b1;

    applyStimulus(0, phase1_last);

    // Asynchronous reset in the middle of OFF with every request pending.
    @(negedge clk_base);
    req   = 3'b111;
    tick  = 1'b0;
    ack   = 1'b0;
    rst_n = 1'b0;
    #2;
    checkAll("async reset", 4'b0000, 3'b000, 0, 0);
    @(posedge clk_base);
    #1;
    checkAll("held reset", 4'b0000, 3'b000, 0, 0);
    @(negedge clk_base);
    rst_n = 1'b1;
    @(posedge clk_base);
    #1;
    checkAll("post reset fault", 4'b1000, 3'b100, 1, 0);

    applyStimulus(phase1_last + 1, vecs.size() - 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
